// File: rtl/lzw_decoder_if.sv
// Code-in / symbol-out handshake bundle for the LZW decoder.
//   code_in, code_valid, code_last : code stream from the source (master drives)
//   code_ready                     : decoder accepts a code this cycle
//   out_data, out_valid, out_last  : decoded symbol stream to the sink
//   out_ready                      : sink accepts the symbol (master drives)
interface lzw_decoder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CODE_WIDTH = 9
);
  logic [CODE_WIDTH-1:0] code_in;
  logic                  code_valid;
  logic                  code_last;
  logic                  code_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output code_in, code_valid, code_last, out_ready,
    input  code_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  code_in, code_valid, code_last, out_ready,
    output code_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/lzw_decoder.sv
// LZW decoder: accepts fixed-width codes, rebuilds the string dictionary on the
// fly and emits decoded symbols through a valid/ready handshake.
//   clk, rst_n : clock, asynchronous active-low reset
//   cs         : session start, sampled only while idle
//   bus        : code input and symbol output handshakes (slave side)
//   busy       : a session is in progress
//   done       : one-cycle pulse when the session completes
//   err        : sticky illegal-code flag, cleared on the next start
//   dict_full  : every dictionary entry has been allocated
module lzw_decoder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CODE_WIDTH = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  lzw_decoder_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          dict_full
);

  localparam int unsigned NumLit     = 2 ** DATA_WIDTH;
  localparam int unsigned DictDepth  = 2 ** CODE_WIDTH - NumLit;
  localparam int unsigned DictAw     = $clog2(DictDepth);
  localparam int unsigned StackDepth = DictDepth + 1;
  localparam int unsigned SpW        = $clog2(StackDepth + 1);
  localparam int unsigned IdxW       = $clog2(StackDepth);

  localparam logic [CODE_WIDTH:0]   NextInit = (CODE_WIDTH + 1)'(NumLit);
  localparam logic [CODE_WIDTH:0]   NextMax  = (CODE_WIDTH + 1)'(2 ** CODE_WIDTH);
  localparam logic [CODE_WIDTH:0]   NextOne  = (CODE_WIDTH + 1)'(1);
  localparam logic [CODE_WIDTH-1:0] LitLimit = CODE_WIDTH'(NumLit);
  localparam logic [SpW-1:0]        SpOne    = SpW'(1);

  typedef enum logic [2:0] {StIdle, StFetch, StWalk, StEmit, StDone, StError} state_e;

  state_e                  state_q, state_d;
  logic [CODE_WIDTH-1:0]   code_q, code_d;
  logic                    last_q, last_d;
  logic                    have_q, have_d;   // code latched, validation pending
  logic                    kwk_q, kwk_d;     // KwKwK: prev_first still to be pushed
  logic                    seen_q, seen_d;   // at least one code decoded this session
  logic [CODE_WIDTH-1:0]   old_q, old_d;
  logic [DATA_WIDTH-1:0]   pf_q, pf_d;
  logic [CODE_WIDTH:0]     next_q, next_d;
  logic [CODE_WIDTH-1:0]   cur_q, cur_d;     // walk pointer along the prefix chain
  logic [SpW-1:0]          sp_q, sp_d;
  logic                    err_q, err_d;

  logic [CODE_WIDTH+DATA_WIDTH-1:0] dict [DictDepth];
  logic [DATA_WIDTH-1:0]            stack [StackDepth];

  logic                             push;
  logic [DATA_WIDTH-1:0]            push_data;
  logic                             dict_we;
  logic [CODE_WIDTH+DATA_WIDTH-1:0] dict_rd;
  logic                             code_bad;
  logic                             full;

  assign full     = (next_q == NextMax);
  assign dict_rd  = dict[DictAw'(cur_q - LitLimit)];
  // Equality with next_code is accepted (KwKwK); a saturated next_code exceeds any code.
  assign code_bad = seen_q ? ({1'b0, code_q} > next_q) : (code_q >= LitLimit);

  always_ff @(posedge clk) begin
    if (push) begin
      stack[IdxW'(sp_q)] <= push_data;
    end
    if (dict_we) begin
      dict[DictAw'(next_q - NextInit)] <= {old_q, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      last_q  <= 1'b0;
      have_q  <= 1'b0;
      kwk_q   <= 1'b0;
      seen_q  <= 1'b0;
      old_q   <= '0;
      pf_q    <= '0;
      next_q  <= NextInit;
      cur_q   <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      last_q  <= last_d;
      have_q  <= have_d;
      kwk_q   <= kwk_d;
      seen_q  <= seen_d;
      old_q   <= old_d;
      pf_q    <= pf_d;
      next_q  <= next_d;
      cur_q   <= cur_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    last_d    = last_q;
    have_d    = have_q;
    kwk_d     = kwk_q;
    seen_d    = seen_q;
    old_d     = old_q;
    pf_d      = pf_q;
    next_d    = next_q;
    cur_d     = cur_q;
    sp_d      = sp_q;
    err_d     = err_q;
    push      = 1'b0;
    push_data = '0;
    dict_we   = 1'b0;

    case (state_q)
      StIdle: begin
        if (cs) begin
          state_d = StFetch;
          err_d   = 1'b0;
          next_d  = NextInit;
          sp_d    = '0;
          seen_d  = 1'b0;
          have_d  = 1'b0;
          kwk_d   = 1'b0;
        end
      end
      StFetch: begin
        if (!have_q) begin
          if (bus.code_valid) begin
            code_d = bus.code_in;
            last_d = bus.code_last;
            have_d = 1'b1;
          end
        end else begin
          have_d = 1'b0;
          if (code_bad) begin
            state_d = StError;
          end else begin
            state_d = StWalk;
            if ({1'b0, code_q} == next_q) begin
              kwk_d = 1'b1;
              cur_d = old_q;
            end else begin
              cur_d = code_q;
            end
          end
        end
      end
      StWalk: begin
        push = 1'b1;
        sp_d = sp_q + SpOne;
        if (kwk_q) begin
          push_data = pf_q;
          kwk_d     = 1'b0;
        end else if (cur_q < LitLimit) begin
          // Final push: this literal is the first symbol of the current string.
          push_data = cur_q[DATA_WIDTH-1:0];
          if (seen_q && !full) begin
            dict_we = 1'b1;
            next_d  = next_q + NextOne;
          end
          pf_d    = cur_q[DATA_WIDTH-1:0];
          old_d   = code_q;
          seen_d  = 1'b1;
          state_d = StEmit;
        end else begin
          push_data = dict_rd[DATA_WIDTH-1:0];
          cur_d     = dict_rd[CODE_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          sp_d = sp_q - SpOne;
          if (sp_q == SpOne) begin
            state_d = last_q ? StDone : StFetch;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      StError: begin
        err_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.code_ready = (state_q == StFetch) && !have_q;
  assign bus.out_valid  = (state_q == StEmit);
  assign bus.out_data   = (state_q == StEmit) ? stack[IdxW'(sp_q - SpOne)] : '0;
  assign bus.out_last   = (state_q == StEmit) && last_q && (sp_q == SpOne);
  assign busy           = (state_q != StIdle);
  assign done           = (state_q == StDone);
  assign err            = err_q;
  assign dict_full      = full;

endmodule

// File: tb/tb_lzw_decoder.sv
// Self-checking bench for lzw_decoder: directed scenarios plus randomized
// sessions, with expected symbols queued from a string-level LZW model and
// checked by an independent output monitor.
module tb_lzw_decoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cs = 1'b0;
  logic busy, done, err, dict_full;

  lzw_decoder_if #(.DATA_WIDTH(8), .CODE_WIDTH(9)) bus();

  lzw_decoder #(.DATA_WIDTH(8), .CODE_WIDTH(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs        (cs),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dict_full (dict_full)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int pop_cnt = 0;
  bit rdy_random = 1'b0;
  bit rdy_force = 1'b1;
  logic [8:0] exp_q[$];  // {last, symbol}

  // Reference model state: a dictionary entry is a slice of the session history.
  int m_next;
  bit m_seen;
  int m_pstart;
  int m_plen;
  logic [7:0] hist[$];
  int ent_start[512];
  int ent_len[512];

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, expv, expv);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  task automatic model_reset();
    m_next = 256;
    m_seen = 1'b0;
    m_pstart = 0;
    m_plen = 0;
    hist.delete();
  endtask

  task automatic model_code(input int c, input bit last, output bit bad);
    logic [7:0] cur[$];
    int st;
    bad = m_seen ? (c > m_next) : (c >= 256);
    if (bad) return;
    st = hist.size();
    if (c < 256) begin
      cur.push_back(c[7:0]);
    end else if (c == m_next) begin
      for (int i = 0; i < m_plen; i++) cur.push_back(hist[m_pstart + i]);
      cur.push_back(hist[m_pstart]);
    end else begin
      for (int i = 0; i < ent_len[c]; i++) cur.push_back(hist[ent_start[c] + i]);
    end
    foreach (cur[i]) begin
      hist.push_back(cur[i]);
      exp_q.push_back({(last && (i == cur.size() - 1)) ? 1'b1 : 1'b0, cur[i]});
    end
    if (m_seen && m_next < 512) begin
      ent_start[m_next] = m_pstart;
      ent_len[m_next] = m_plen + 1;
      m_next++;
    end
    m_pstart = st;
    m_plen = cur.size();
    m_seen = 1'b1;
  endtask

  task automatic send_code(input int c, input bit last);
    bit bad;
    bit hs;
    model_code(c, last, bad);
    @(posedge clk);
    #1;
    bus.code_in = 9'(c);
    bus.code_valid = 1'b1;
    bus.code_last = last;
    hs = 1'b0;
    for (int n = 0; n < 3000 && !hs; n++) begin
      @(negedge clk);
      hs = bus.code_ready;
    end
    if (!hs) fail_now("code_accept");
    @(posedge clk);
    #1;
    bus.code_valid = 1'b0;
    bus.code_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = !busy;
    end
    if (!ok) fail_now("wait_idle");
  endtask

  task automatic wait_code_ready();
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = bus.code_ready;
    end
    if (!ok) fail_now("wait_code_ready");
  endtask

  task automatic wait_out_valid();
    bit ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = bus.out_valid;
    end
    if (!ok) fail_now("wait_out_valid");
  endtask

  task automatic start_session();
    wait_idle();
    model_reset();
    @(negedge clk);
    cs = 1'b1;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_dict_full"}, int'(dict_full), 0);
    chk({tag, "_code_ready"}, int'(bus.code_ready), 0);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_out_data"}, int'(bus.out_data), 0);
    chk({tag, "_out_last"}, int'(bus.out_last), 0);
  endtask

  // Sink-side ready driver.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = rdy_random ? ($urandom_range(0, 3) != 0) : rdy_force;
    end
  end

  // Output monitor / scoreboard.
  initial begin
    logic [8:0] e;
    bit stall = 1'b0;
    logic [7:0] sd = '0;
    logic sl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      chk("handshake_exclusive", int'(bus.code_ready && bus.out_valid), 0);
      if (done) done_cnt++;
      if (stall && bus.out_valid) begin
        chk("hold_data", int'(bus.out_data), int'(sd));
        chk("hold_last", int'(bus.out_last), int'(sl));
      end
      if (bus.out_valid && bus.out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_symbol: got 0x%0h, required no symbol", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("sym_data", int'(bus.out_data), int'(e[7:0]));
          chk("sym_last", int'(bus.out_last), int'(e[8]));
        end
      end
      stall = bus.out_valid && !bus.out_ready;
      sd = bus.out_data;
      sl = bus.out_last;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int p0;
    int c;
    int n;
    bus.code_in = '0;
    bus.code_valid = 1'b0;
    bus.code_last = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Mixed literal / KwKwK stream
    start_session();
    d0 = done_cnt;
    p0 = pop_cnt;
    send_code(8'h41, 1'b0);
    send_code(8'h42, 1'b0);
    send_code(256, 1'b0);
    send_code(258, 1'b1);
    wait_idle();
    chk("mixed_pops", pop_cnt - p0, 7);
    chk("mixed_done", done_cnt - d0, 1);
    chk("mixed_err", int'(err), 0);
    chk("mixed_queue_empty", exp_q.size(), 0);

    // Single-literal latency: accepted at edge k, out_valid after edge k+2
    start_session();
    send_code(8'h5A, 1'b1);
    @(negedge clk);
    chk("lat_k0_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_k1_valid", int'(bus.out_valid), 0);
    @(negedge clk);
    chk("lat_k2_valid", int'(bus.out_valid), 1);
    chk("lat_k2_data", int'(bus.out_data), 8'h5A);
    chk("lat_k2_last", int'(bus.out_last), 1);
    @(negedge clk);
    chk("lat_done_pulse", int'(done), 1);
    wait_idle();

    // Backpressure during the 256 expansion
    start_session();
    send_code(8'h41, 1'b0);
    send_code(8'h42, 1'b0);
    wait_code_ready();
    rdy_force = 1'b0;
    send_code(256, 1'b1);
    wait_out_valid();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_data", int'(bus.out_data), 8'h41);
      chk("bp_valid", int'(bus.out_valid), 1);
      chk("bp_code_ready", int'(bus.code_ready), 0);
    end
    rdy_force = 1'b1;
    wait_idle();
    chk("bp_queue_empty", exp_q.size(), 0);

    // Illegal first code
    start_session();
    d0 = done_cnt;
    p0 = pop_cnt;
    send_code(300, 1'b1);
    wait_idle();
    chk("ill_first_err", int'(err), 1);
    chk("ill_first_pops", pop_cnt - p0, 0);
    chk("ill_first_done", done_cnt - d0, 0);

    // New start clears err; code above next_code is illegal
    start_session();
    @(negedge clk);
    chk("ill_err_cleared", int'(err), 0);
    d0 = done_cnt;
    send_code(8'h41, 1'b0);
    send_code(8'h42, 1'b0);
    send_code(260, 1'b1);
    wait_idle();
    chk("ill_later_err", int'(err), 1);
    chk("ill_later_done", done_cnt - d0, 0);
    chk("ill_later_queue_empty", exp_q.size(), 0);

    // Dictionary saturation
    start_session();
    for (int i = 0; i < 256; i++) send_code(i, 1'b0);
    wait_code_ready();
    chk("sat_not_full_yet", int'(dict_full), 0);
    send_code(0, 1'b0);
    wait_code_ready();
    chk("sat_full", int'(dict_full), 1);
    send_code(511, 1'b1);
    wait_idle();
    chk("sat_full_after", int'(dict_full), 1);
    chk("sat_err", int'(err), 0);
    chk("sat_queue_empty", exp_q.size(), 0);

    // Mid-session reset while stalled in EMIT
    start_session();
    rdy_force = 1'b0;
    send_code(8'h41, 1'b0);
    wait_out_valid();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    rdy_force = 1'b1;
    d0 = done_cnt;
    start_session();
    send_code(8'h41, 1'b1);
    wait_idle();
    chk("midrst_done", done_cnt - d0, 1);
    chk("midrst_queue_empty", exp_q.size(), 0);

    // Randomized sessions with random sink backpressure
    rdy_random = 1'b1;
    for (int s = 0; s < 12; s++) begin
      start_session();
      d0 = done_cnt;
      n = $urandom_range(1, 24);
      for (int j = 0; j < n; j++) begin
        if (!m_seen) begin
          c = $urandom_range(0, 255);
        end else begin
          case ($urandom_range(0, 3))
            0: c = $urandom_range(0, 255);
            1: c = m_next;
            default: c = (m_next > 256) ? $urandom_range(256, m_next - 1) : $urandom_range(0, 255);
          endcase
        end
        send_code(c, j == n - 1);
      end
      wait_idle();
      chk("rand_done", done_cnt - d0, 1);
      chk("rand_err", int'(err), 0);
      chk("rand_queue_empty", exp_q.size(), 0);
    end
    rdy_random = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lzw_decoder.md
# lzw_decoder

LZW decoder pairing with the team's `encoder`. It accepts a stream of fixed-width codes, rebuilds the string dictionary on the fly, and emits the decoded symbol stream through a valid/ready handshake. It sits downstream of the encoder's output-code memory and drives the byte sink that the verification bench compares against the encoder's input memory.

## Interface
- `DATA_WIDTH`, default 8: symbol width. Codes 0..2^DATA_WIDTH-1 are implicit literals.
- `CODE_WIDTH`, default 9: code width; must be greater than `DATA_WIDTH`. The dictionary holds entries 2^DATA_WIDTH..2^CODE_WIDTH-1.
- `clk` in 1: single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cs` in 1: start. Sampled only in IDLE; a high sample begins a session.
- `code_in` in CODE_WIDTH: code presented by the source.
- `code_valid` in 1: `code_in` is valid.
- `code_last` in 1: qualifies `code_in` as the final code of the session.
- `code_ready` out 1: decoder accepts a code this cycle.
- `out_data` out DATA_WIDTH: decoded symbol.
- `out_valid` out 1: `out_data` is valid.
- `out_last` out 1: this is the final symbol of the final code.
- `out_ready` in 1: sink accepts the symbol.
- `busy` out 1: state is not IDLE.
- `done` out 1: one-cycle pulse when the session completes.
- `err` out 1: sticky illegal-code flag. Cleared on the next start.
- `dict_full` out 1: `next_code` has reached 2^CODE_WIDTH.

## Operation
**States:** IDLE, FETCH, WALK, EMIT, DONE, ERROR.

**Storage**
- Dictionary RAM: entries of {prefix[CODE_WIDTH], suffix[DATA_WIDTH]}.
- LIFO stack: DATA_WIDTH wide, depth 2^CODE_WIDTH-2^DATA_WIDTH+1.
- Registers: `old_code`, `prev_first`, `next_code` (resets to 2^DATA_WIDTH), `first_flag`, `last_flag`.

**State transitions**
- IDLE: on `cs`=1, go to FETCH and clear `err`, `next_code`, the stack, and `first_flag`.
- FETCH: `code_ready`=1. On a handshake, latch the code and `code_last`. Then validate the code:
  - First code of the session must be < 2^DATA_WIDTH.
  - Later codes must be <= `next_code`.
  - A code equal to `next_code` while `dict_full`=1 is impossible by width.
  - If validation fails, go to ERROR. Otherwise go to WALK.
- WALK: each cycle, push one suffix and follow the prefix chain.
  - Literal code (< 2^DATA_WIDTH): push the code itself and end the walk.
  - KwKwK case (code == `next_code`): first push `prev_first`, then walk `old_code`.
  - On the final push, the pushed literal is the first symbol of the current string.
    - If this is not the first code and `dict_full`=0, write {`old_code`, that first symbol} at `next_code` and increment `next_code`.
    - Update `prev_first` and set `old_code` to the current code.
    - Go to EMIT.
- EMIT: `out_valid`=1 and `out_data` = top of stack. Each handshake pops one entry.
  - `out_last` = `last_flag` AND this is the final stack entry.
  - After the final pop, go to DONE if `last_flag` is set, otherwise to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- ERROR: set `err`=1, then IDLE. No symbols are emitted for the offending code.

**Width rules**
- Code compares are unsigned, CODE_WIDTH bits.
- `next_code` is CODE_WIDTH+1 bits and saturates at 2^CODE_WIDTH. Once saturated, no further dictionary writes occur and decoding continues.

## Timing
- **Reset:** every output is 0. State = IDLE, stack empty, `next_code`=2^DATA_WIDTH.
- **Reset mid-session:** immediately aborts the session. No partial `done` is issued.
- **Code handshake:** a code accepted at edge k gives WALK in cycles k+1..k+L, where L is the string length. `out_valid` first rises after edge k+L+1. A literal therefore gives `out_valid` from k+2.
- **Output handshake:** one symbol per cycle while `out_ready`=1. While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- **Handshake exclusivity:** `code_ready` and `out_valid` are never high in the same cycle.
- **Turnaround:** after the final non-last pop, `code_ready` is high in the next cycle. After the final last pop, `done` pulses in the next cycle.
- **Start gating:** `cs` is ignored while `busy`=1.

## Test plan
- **Mixed literal/KwKwK stream:** reset, `cs`, then codes 0x41, 0x42, 256, 258 (last) with `out_ready`=1.
  - Required output: 0x41 0x42 0x41 0x42 0x41 0x42 0x41, with `out_last` on the 7th symbol.
  - Dictionary: 256=(65,'B'), 257=(66,'A'), 258=(256,'A').
  - `done` pulses once and `err`=0.
- **Single-literal latency:** code 0x5A with `code_last`, accepted at edge k.
  - `out_valid` rises at k+2 with `out_data`=0x5A and `out_last`=1.
  - `done` pulses at the cycle after the pop.
- **Backpressure:** during the 256 expansion, hold `out_ready`=0 for 3 cycles.
  - `out_data` holds 0x41 and `code_ready`=0.
  - Output resumes in order with no lost or duplicated symbols.
- **Illegal codes:**
  - First code 300: `err`=1, no `out_valid`, return to IDLE.
  - After codes 0x41, 0x42 (`next_code`=257), code 260: `err`=1.
  - A new `cs` clears `err`.
- **Dictionary saturation:** feed 257 literal codes (0x00..0xFF, 0x00), then code 511.
  - `dict_full`=1 after the 257th code.
  - Code 511 decodes to 0xFF 0x00 and `next_code` stays 512.
- **Mid-session reset:** assert `rst_n`=0 during EMIT.
  - All outputs go to 0 immediately and state = IDLE.
  - A subsequent session decoding 0x41 works correctly.
